uart_rx_disp: RTL and testbench



---
 rtl/uart_rx_disp.sv | 168 ++++++++++++++++
 tb/tb_uart_rx_disp.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_disp.sv
// UART receiver (8N1, LSB first) that assembles a {previous, latest} display word.
// Define UART_PARITY_EN to add an even-parity bit and the sticky par_err output.
module uart_rx_disp #(
    parameter int BIT_DIV  = 10416,
    parameter int HALF_DIV = BIT_DIV / 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    input  logic        err_clr,
    output logic [15:0] seg,
    output logic        rx_valid,
    output logic [7:0]  rx_byte,
    output logic        frame_err,
`ifdef UART_PARITY_EN
    output logic        par_err,
`endif
    output logic        busy
);
    localparam logic [15:0] BIT_RL  = 16'(BIT_DIV - 1);
    localparam logic [15:0] HALF_RL = 16'(HALF_DIV - 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, BREAK
    } state_e;

    state_e      state_q, state_d;
    logic        sync1_q, sync2_q;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic [15:0] seg_q, seg_d;
    logic [7:0]  byte_q, byte_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;
    logic        rx_s, tick, par_ok;

`ifdef UART_PARITY_EN
    logic        perr_q, perr_d;
    logic        pbad_q, pbad_d;
    assign par_ok  = !pbad_q;
    assign par_err = perr_q;
`else
    assign par_ok  = 1'b1;
`endif

    assign rx_s = sync2_q;
    assign tick = (baud_q == 16'd0);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        seg_d   = seg_q;
        byte_d  = byte_q;
        valid_d = 1'b0;
        ferr_d  = err_clr ? 1'b0 : ferr_q;
`ifdef UART_PARITY_EN
        perr_d  = err_clr ? 1'b0 : perr_q;
        pbad_d  = pbad_q;
`endif
        if (state_q != IDLE) begin
            baud_d = tick ? BIT_RL : baud_q - 16'd1;
        end
        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    baud_d  = HALF_RL;
                end
            end
            START: begin
                if (tick) begin
                    state_d = rx_s ? IDLE : DATA;
                    bit_d   = 3'd0;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                if (tick) begin
                    pbad_d  = rx_s ^ (^shift_q);
                    state_d = STOP;
                    if (rx_s ^ (^shift_q)) begin
                        perr_d = 1'b1;
                    end
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (rx_s) begin
                        state_d = IDLE;
                        if (par_ok) begin
                            seg_d   = {seg_q[7:0], shift_q};
                            byte_d  = shift_q;
                            valid_d = 1'b1;
                        end
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end
            end
            // a held-low line parks here so it reports one error, not many
            BREAK: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= IDLE;
            baud_q  <= 16'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            seg_q   <= 16'h0000;
            byte_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_PARITY_EN
            perr_q  <= 1'b0;
            pbad_q  <= 1'b0;
`endif
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            seg_q   <= seg_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
`ifdef UART_PARITY_EN
            perr_q  <= perr_d;
            pbad_q  <= pbad_d;
`endif
        end
    end

    assign seg       = seg_q;
    assign rx_byte   = byte_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_disp.sv
// Bench for uart_rx_disp at BIT_DIV=16: frame table plus glitch, break,
// mid-frame reset and (with UART_PARITY_EN) parity sequences.
module tb_uart_rx_disp;
    localparam int BD = 16;
`ifdef UART_PARITY_EN
    localparam int NPAR = 1;
`else
    localparam int NPAR = 0;
`endif

    logic        clk = 1'b0;
    logic        reset, rx, err_clr;
    logic [15:0] seg;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        frame_err, busy;
`ifdef UART_PARITY_EN
    logic        par_err;
`endif

    uart_rx_disp #(.BIT_DIV(BD)) dut (
        .clk(clk),
        .reset(reset),
        .rx(rx),
        .err_clr(err_clr),
        .seg(seg),
        .rx_valid(rx_valid),
        .rx_byte(rx_byte),
        .frame_err(frame_err),
`ifdef UART_PARITY_EN
        .par_err(par_err),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] seg;
        logic [7:0]  b;
        int          cyc;
        logic        dbl;
    } obs_t;

    typedef struct {
        logic [15:0] seg;
        logic [7:0]  b;
    } exp_t;

    typedef struct {
        logic [7:0]  d;
        logic        stop;
        logic [15:0] seg;
        logic        ferr;
    } vec_t;

    obs_t obs [0:63];
    int   nobs = 0;
    int   cyc = 0;
    int   ferr_rises = 0;
    logic prev_v = 1'b0;
    logic prev_f = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid === 1'b1 && nobs < 64) begin
            obs[nobs] = '{seg, rx_byte, cyc, prev_v};
            nobs++;
        end
        if (frame_err === 1'b1 && !prev_f) ferr_rises++;
        prev_v = (rx_valid === 1'b1);
        prev_f = (frame_err === 1'b1);
    end

    int          checks = 0;
    int          errors = 0;
    int          rd = 0;
    logic [15:0] mseg = 16'h0000;
    exp_t        exp_q[$];
    vec_t        tbl[4];

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(logic v);
        rx = v;
        tick(BD);
    endtask

    task automatic send_frame(logic [7:0] d, logic stop, logic bad_par);
        if (stop && !bad_par) begin
            mseg = {mseg[7:0], d};
            exp_q.push_back('{mseg, d});
        end
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_PARITY_EN
        send_bit((^d) ^ bad_par);
`endif
        send_bit(stop);
        rx = 1'b1;
    endtask

    task automatic drain();
        exp_t e;
        while (rd < nobs) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got byte %0h want none", obs[rd].b);
            end else begin
                e = exp_q.pop_front();
                chk("sb_seg", 32'(obs[rd].seg), 32'(e.seg));
                chk("sb_byte", 32'(obs[rd].b), 32'(e.b));
            end
            chk("valid_one_cycle", 32'(obs[rd].dbl), 32'd0);
            rd++;
        end
        chk("sb_pending", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int n0, f0, c0;
        tbl[0] = '{8'h12, 1'b1, 16'h0012, 1'b0};
        tbl[1] = '{8'h34, 1'b1, 16'h1234, 1'b0};
        tbl[2] = '{8'hA5, 1'b0, 16'h1234, 1'b1};
        tbl[3] = '{8'h5A, 1'b1, 16'h345A, 1'b1};

        reset = 1'b1;
        rx = 1'b1;
        err_clr = 1'b0;
        tick(3);
        chk("rst_seg", 32'(seg), 32'h0);
        chk("rst_byte", 32'(rx_byte), 32'h0);
        chk("rst_valid", 32'(rx_valid), 32'h0);
        chk("rst_ferr", 32'(frame_err), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        tick(2);

        for (int i = 0; i < 4; i++) begin
            n0 = nobs;
            c0 = cyc;
            send_frame(tbl[i].d, tbl[i].stop, 1'b0);
            tick(2 * BD);
            chk("valid_count", 32'(nobs - n0), 32'(tbl[i].stop));
            if (i == 0) chk("latency", 32'(obs[n0].cyc - c0), 32'(BD * (19 + 2 * NPAR) / 2 + 3));
            drain();
            chk("tbl_seg", 32'(seg), 32'(tbl[i].seg));
            chk("tbl_ferr", 32'(frame_err), 32'(tbl[i].ferr));
            chk("tbl_busy", 32'(busy), 32'h0);
        end
        chk("rx_byte_last", 32'(rx_byte), 32'h5A);

        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("ferr_cleared", 32'(frame_err), 32'h0);

        n0 = nobs;
        rx = 1'b0;
        tick(4);
        chk("glitch_busy", 32'(busy), 32'h1);
        rx = 1'b1;
        tick(BD / 2 + 3);
        chk("glitch_idle", 32'(busy), 32'h0);
        chk("glitch_seg", 32'(seg), 32'h345A);
        chk("glitch_novalid", 32'(nobs - n0), 32'h0);

        n0 = nobs;
        f0 = ferr_rises;
        rx = 1'b0;
        tick(20 * BD);
        chk("brk_ferr_set", 32'(frame_err), 32'h1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        tick(20 * BD);
        chk("brk_no_repeat", 32'(frame_err), 32'h0);
        chk("brk_busy", 32'(busy), 32'h1);
        rx = 1'b1;
        tick(BD);
        chk("brk_idle", 32'(busy), 32'h0);
        chk("brk_one_err", 32'(ferr_rises - f0), 32'h1);
        chk("brk_novalid", 32'(nobs - n0), 32'h0);
        send_frame(8'h3C, 1'b1, 1'b0);
        tick(BD);
        drain();
        chk("post_brk_seg", 32'(seg), 32'h5A3C);

        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'(8'h7E >> i));
        rx = 1'b1;
        tick(BD / 2);
        reset = 1'b1;
        #1;
        chk("mid_rst_seg", 32'(seg), 32'h0);
        chk("mid_rst_byte", 32'(rx_byte), 32'h0);
        chk("mid_rst_valid", 32'(rx_valid), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        tick(2);
        reset = 1'b0;
        mseg = 16'h0000;
        tick(BD);
        send_frame(8'h7E, 1'b1, 1'b0);
        tick(BD);
        drain();
        chk("post_rst_seg", 32'(seg), 32'h007E);

`ifdef UART_PARITY_EN
        chk("par_err_idle", 32'(par_err), 32'h0);
        n0 = nobs;
        send_frame(8'h03, 1'b1, 1'b1);
        tick(BD);
        chk("par_err_set", 32'(par_err), 32'h1);
        chk("par_novalid", 32'(nobs - n0), 32'h0);
        chk("par_seg_hold", 32'(seg), 32'h007E);
        send_frame(8'h03, 1'b1, 1'b0);
        tick(BD);
        drain();
        chk("par_good_seg", 32'(seg), 32'h7E03);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("par_err_clr", 32'(par_err), 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
